// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result output stage.
//   ALU_WIDTH    : datapath width, matches the result-select mux
//   skid_state_t : skid-buffer occupancy encoding (2'd3 is illegal)
//   flags_t      : per-entry status bits stored alongside the result
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   // One state per occupancy level; 2'd3 never occurs in normal operation
   // and is steered back to ST_EMPTY by the next-state logic.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

   // Status bits carried with every entry; zero/neg are captured from the
   // incoming result so they never depend on registered data.
   typedef struct packed {
      logic carry;
      logic ovf;
      logic zero;
      logic neg;
   } flags_t;

   localparam int FLAGS_W = $bits(flags_t);

endpackage

// File: rtl/alu_result_skid_if.sv
// -----------------------------------------------------------------------------
// alu_result_skid_if
// Handshake bundle between the result mux, the output stage and the consumer.
//   in_valid/in_ready/in_result/in_carry/in_ovf : upstream side
//   out_valid/out_ready/out_result/out_zero/out_neg/out_carry/out_ovf :
//                                                 downstream side
//   dbg_state : current skid-buffer occupancy, for observation only
// Modports: slave = the output stage, master = the environment around it.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. A source holding valid=1 keeps its payload stable until the beat
// transfers; ready may change freely and never depends combinationally on
// valid in this stage.
// -----------------------------------------------------------------------------
interface alu_result_skid_if #(
   parameter int WIDTH = alu_pkg::ALU_WIDTH
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_result;
   logic                   in_carry;
   logic                   in_ovf;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_result;
   logic                   out_zero;
   logic                   out_neg;
   logic                   out_carry;
   logic                   out_ovf;
   alu_pkg::skid_state_t   dbg_state;

   modport slave (
      input  in_valid, in_result, in_carry, in_ovf, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_neg,
             out_carry, out_ovf, dbg_state
   );

   modport master (
      output in_valid, in_result, in_carry, in_ovf, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_neg,
             out_carry, out_ovf, dbg_state
   );
endinterface

// File: rtl/alu_flag_gen.sv
// -----------------------------------------------------------------------------
// alu_flag_gen
// Combinational zero/negative flag derivation for a WIDTH-bit value.
//   i_value : value to inspect
//   o_zero  : 1 when i_value == 0
//   o_neg   : sign bit of i_value
// -----------------------------------------------------------------------------
module alu_flag_gen #(
   parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
   input  logic [WIDTH-1:0] i_value,
   output logic             o_zero,
   output logic             o_neg
);
   assign o_zero = (i_value == '0);
   assign o_neg  = i_value[WIDTH-1];
endmodule

// File: rtl/alu_result_skid.sv
// -----------------------------------------------------------------------------
// alu_result_skid
// Registered output stage behind the ALU result mux. Captures result plus
// carry/overflow, derives zero/neg at accept time, and hands entries to the
// consumer through a 2-entry skid buffer so in_ready comes straight from the
// state register.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : alu_result_skid_if.slave (upstream + downstream handshake)
// Optional (macro ALU_STICKY_OVF_EN):
//   clr_sticky : clears ovf_sticky (an overflow emit in the same cycle wins)
//   ovf_sticky : set by any emitted entry carrying ovf=1
// -----------------------------------------------------------------------------
module alu_result_skid
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_result_skid_if.slave      bus
`ifdef ALU_STICKY_OVF_EN
   ,
   input  logic                  clr_sticky,
   output logic                  ovf_sticky
`endif
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      flags_t           flags;
   } entry_t;

   skid_state_t r_state;
   skid_state_t w_state_nxt;
   entry_t      r_m;          // main register, drives out_*
   entry_t      r_s;          // skid register, second entry
   entry_t      w_in_entry;
   logic        w_in_zero;
   logic        w_in_neg;
   logic        w_out_valid;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_emit;
   logic        w_load_m_in;
   logic        w_load_m_s;
   logic        w_load_s;

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .i_value (bus.in_result),
      .o_zero  (w_in_zero),
      .o_neg   (w_in_neg)
   );

   assign w_in_entry.result      = bus.in_result;
   assign w_in_entry.flags.carry = bus.in_carry;
   assign w_in_entry.flags.ovf   = bus.in_ovf;
   assign w_in_entry.flags.zero  = w_in_zero;
   assign w_in_entry.flags.neg   = w_in_neg;

   // Decoded only from the state flop, so out_ready has no path to in_ready.
   // The illegal encoding reports neither valid nor ready for its one cycle.
   assign w_out_valid = (r_state == ST_ONE) || (r_state == ST_TWO);
   assign w_in_ready  = (r_state == ST_EMPTY) || (r_state == ST_ONE);

   assign w_accept = bus.in_valid & w_in_ready;
   assign w_emit   = w_out_valid & bus.out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_load_m_in = 1'b0;
      w_load_m_s  = 1'b0;
      w_load_s    = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_load_m_in = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_accept && w_emit) begin
               w_load_m_in = 1'b1;
            end else if (w_accept) begin
               w_load_s    = 1'b1;
               w_state_nxt = ST_TWO;
            end else if (w_emit) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_emit) begin
               w_load_m_s  = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_m     <= '0;
         r_s     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_m_in) begin
            r_m <= w_in_entry;
         end else if (w_load_m_s) begin
            r_m <= r_s;
         end
         if (w_load_s) begin
            r_s <= w_in_entry;
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_result = r_m.result;
   assign bus.out_zero   = r_m.flags.zero;
   assign bus.out_neg    = r_m.flags.neg;
   assign bus.out_carry  = r_m.flags.carry;
   assign bus.out_ovf    = r_m.flags.ovf;
   assign bus.dbg_state  = r_state;

`ifdef ALU_STICKY_OVF_EN
   logic r_ovf_sticky;

   // Set is checked before clear so an overflow leaving the stage is never
   // lost to a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf_sticky <= 1'b0;
      end else if (w_emit && r_m.flags.ovf) begin
         r_ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
         r_ovf_sticky <= 1'b0;
      end
   end

   assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_alu_result_skid.sv
// -----------------------------------------------------------------------------
// tb_alu_result_skid
// Directed bench for alu_result_skid. Inputs change on the falling edge and
// outputs are checked on the falling edge, half a period after the DUT's
// rising edge. Build with +define+ALU_STICKY_OVF_EN to cover the sticky flag.
// -----------------------------------------------------------------------------
module tb_alu_result_skid;
   import alu_pkg::*;

   localparam int W = ALU_WIDTH;

   logic clk;
   logic rst;
`ifdef ALU_STICKY_OVF_EN
   logic clr_sticky;
   logic ovf_sticky;
`endif

   alu_result_skid_if #(.WIDTH(W)) bus ();

   alu_result_skid #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef ALU_STICKY_OVF_EN
      ,
      .clr_sticky (clr_sticky),
      .ovf_sticky (ovf_sticky)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one rising edge and land on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [W-1:0] res,
                        input logic c, input logic o);
      bus.in_valid  = v;
      bus.in_result = res;
      bus.in_carry  = c;
      bus.in_ovf    = o;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [W-1:0] exp_v;

      rst           = 1'b1;
      bus.out_ready = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
`ifdef ALU_STICKY_OVF_EN
      clr_sticky = 1'b0;
`endif
      @(negedge clk);
      step();
      step();

      // Reset state: flags forced to 0 even though result is 0.
      chk("rst_out_valid", W'(bus.out_valid), 0);
      chk("rst_in_ready",  W'(bus.in_ready), 1);
      chk("rst_result",    bus.out_result, 0);
      chk("rst_zero",      W'(bus.out_zero), 0);
      chk("rst_neg",       W'(bus.out_neg), 0);
      chk("rst_carry",     W'(bus.out_carry), 0);
      chk("rst_ovf",       W'(bus.out_ovf), 0);
      chk("rst_state",     W'(bus.dbg_state), W'(ST_EMPTY));
`ifdef ALU_STICKY_OVF_EN
      chk("rst_sticky",    W'(ovf_sticky), 0);
`endif

      // Zero result: appears the cycle after accept with zero=1.
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("zero_out_valid", W'(bus.out_valid), 1);
      chk("zero_zero",      W'(bus.out_zero), 1);
      chk("zero_neg",       W'(bus.out_neg), 0);
      chk("zero_in_ready",  W'(bus.in_ready), 1);
      step();
      chk("zero_drained", W'(bus.out_valid), 0);

      // Stream 1..8 at full rate: each value visible one cycle after accept.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, W'(i), i[0], i[1]);
         exp_q.push_back(W'(i));
         step();
         exp_v = exp_q.pop_front();
         chk("stream_valid",  W'(bus.out_valid), 1);
         chk("stream_result", bus.out_result, exp_v);
         chk("stream_carry",  W'(bus.out_carry), W'(exp_v[0]));
         chk("stream_ovf",    W'(bus.out_ovf), W'(exp_v[1]));
         chk("stream_zero",   W'(bus.out_zero), 0);
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
      chk("stream_drained", W'(bus.out_valid), 0);

      // Fill both entries under backpressure.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h8000_0000, 1'b0, 1'b0);
      step();
      chk("bp1_in_ready", W'(bus.in_ready), 1);
      chk("bp1_result",   bus.out_result, 32'h8000_0000);
      chk("bp1_neg",      W'(bus.out_neg), 1);
      drive(1'b1, 32'h0000_0005, 1'b0, 1'b0);
      step();
      // Full: offer a value that must be ignored.
      drive(1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
      chk("two_state",    W'(bus.dbg_state), W'(ST_TWO));
      chk("two_in_ready", W'(bus.in_ready), 0);
      chk("two_result",   bus.out_result, 32'h8000_0000);
      chk("two_neg",      W'(bus.out_neg), 1);
      step();
      chk("two_hold_result", bus.out_result, 32'h8000_0000);
      chk("two_hold_state",  W'(bus.dbg_state), W'(ST_TWO));
      bus.out_ready = 1'b1;
      step();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("drain_result",   bus.out_result, 32'h0000_0005);
      chk("drain_neg",      W'(bus.out_neg), 0);
      chk("drain_in_ready", W'(bus.in_ready), 1);
      step();
      chk("drain_empty", W'(bus.out_valid), 0);
      chk("drain_no_dead", W'(bus.out_result != 32'h0000_DEAD), 1);

      // Reset while full discards both entries; accept during reset is lost.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h0000_000A, 1'b1, 1'b0);
      step();
      drive(1'b1, 32'h0000_000B, 1'b0, 1'b0);
      step();
      chk("prerst_state", W'(bus.dbg_state), W'(ST_TWO));
      rst = 1'b1;
      drive(1'b1, 32'h0000_000C, 1'b1, 1'b1);
      step();
      chk("midrst_out_valid", W'(bus.out_valid), 0);
      chk("midrst_result",    bus.out_result, 0);
      chk("midrst_carry",     W'(bus.out_carry), 0);
      chk("midrst_in_ready",  W'(bus.in_ready), 1);
      step();
      chk("rstacc_out_valid", W'(bus.out_valid), 0);
      chk("rstacc_result",    bus.out_result, 0);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h0000_0007, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("post_rst_valid",  W'(bus.out_valid), 1);
      chk("post_rst_result", bus.out_result, 32'h0000_0007);
      step();
      chk("post_rst_empty", W'(bus.out_valid), 0);

`ifdef ALU_STICKY_OVF_EN
      // Overflow entry sets the sticky flag when it is emitted.
      drive(1'b1, 32'h0000_0010, 1'b0, 1'b1);
      step();
      chk("sticky_pre", W'(ovf_sticky), 0);
      drive(1'b1, 32'h0000_0011, 1'b0, 1'b0);
      step();
      chk("sticky_set", W'(ovf_sticky), 1);
      drive(1'b1, 32'h0000_0012, 1'b0, 1'b0);
      step();
      chk("sticky_keep1", W'(ovf_sticky), 1);
      drive(1'b1, 32'h0000_0013, 1'b0, 1'b0);
      step();
      chk("sticky_keep2", W'(ovf_sticky), 1);
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
      chk("sticky_keep3", W'(ovf_sticky), 1);
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      chk("sticky_clr", W'(ovf_sticky), 0);
      // Clear coinciding with an overflow emit: the set wins.
      drive(1'b1, 32'h0000_0020, 1'b0, 1'b1);
      step();
      drive(1'b0, '0, 1'b0, 1'b0);
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      chk("sticky_set_wins", W'(ovf_sticky), 1);
`endif

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
